// File: rtl/rand_draw_arbiter.sv
// Round-robin arbiter sharing one free-running LFSR among game requesters.
// Reduces each draw to [0, Range) by mask-and-reject with a bounded fallback.
module rand_draw_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 7
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*WIDTH-1:0] Range_Flat,
    input  logic [WIDTH-1:0]         Rnd_In,
    output logic                     Gen,
    output logic [NUM_REQ-1:0]       Grant,
    output logic                     Valid,
    output logic [WIDTH-1:0]         Rnd_Out,
    output logic                     Busy
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        SAMPLE,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     idx;
    logic [WIDTH-1:0]  range_q;
    logic [WIDTH-1:0]  mask_q;
    logic [3:0]        retry;

    logic              found;
    logic [IW-1:0]     pick;
    logic [WIDTH-1:0]  sel_range;
    logic [WIDTH-1:0]  sel_mask;
    logic [WIDTH-1:0]  range_m1;
    logic [WIDTH-1:0]  m_s;
    logic              accept;
    logic              fallback;

    // First asserted request at or after the rotating pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && Req[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    // Smear Range-1 right to get the smallest covering all-ones mask.
    always_comb begin
        sel_range = Range_Flat[int'(pick)*WIDTH +: WIDTH];
        range_m1  = sel_range - 1'b1;
        sel_mask  = range_m1;
        for (int i = 1; i < WIDTH; i++) begin
            sel_mask = sel_mask | (range_m1 >> i);
        end
        if (sel_range == '0) begin
            sel_mask = '1;
        end
    end

    assign m_s      = Rnd_In & mask_q;
    assign accept   = (range_q == '0) || (m_s < range_q);
    assign fallback = (retry == 4'(MAX_RETRY));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = SEED;
            SEED:    state_nxt = SAMPLE;
            SAMPLE:  if (accept || fallback) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rr_ptr  <= '0;
            idx     <= '0;
            range_q <= '0;
            mask_q  <= '0;
            retry   <= '0;
            Rnd_Out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        idx     <= pick;
                        range_q <= sel_range;
                        mask_q  <= sel_mask;
                    end
                end
                SEED: retry <= '0;
                SAMPLE: begin
                    if (accept) begin
                        Rnd_Out <= m_s;
                    end else if (fallback) begin
                        Rnd_Out <= m_s - range_q;
                    end else begin
                        retry <= retry + 1'b1;
                    end
                end
                DONE: begin
                    rr_ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Gen   = (state == IDLE);
    assign Busy  = (state != IDLE);
    assign Valid = (state == DONE);
    assign Grant = (state == DONE) ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: tb/tb_rand_draw_arbiter.sv
// Scoreboard bench for rand_draw_arbiter: directed draws with hand-computed
// results, checked by an independent monitor on each Valid pulse.
module tb_rand_draw_arbiter;

    logic        Clk;
    logic        Rst;
    logic [3:0]  Req;
    logic [31:0] Range_Flat;
    logic [7:0]  Rnd_In;
    logic        Gen;
    logic [3:0]  Grant;
    logic        Valid;
    logic [7:0]  Rnd_Out;
    logic        Busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] g;
        logic [7:0] v;
        int         c;
    } exp_t;

    exp_t sb[$];

    rand_draw_arbiter #(
        .NUM_REQ(4),
        .WIDTH(8),
        .MAX_RETRY(7)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Req(Req),
        .Range_Flat(Range_Flat),
        .Rnd_In(Rnd_In),
        .Gen(Gen),
        .Grant(Grant),
        .Valid(Valid),
        .Rnd_Out(Rnd_Out),
        .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: every Valid must match the oldest expected draw.
    always @(negedge Clk) begin
        if (Rst === 1'b1 && Valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got=1 want=0 grant=%b", Grant);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("grant", 32'(Grant), 32'(e.g));
                chk("rnd_out", 32'(Rnd_Out), 32'(e.v));
                chk("latency", 32'(cyc), 32'(e.c));
            end
        end
    end

    // One draw: nrej samples of rej, then one sample of acc.
    task automatic draw(input logic [3:0] req, input bit hold,
                        input logic [7:0] rej, input int nrej,
                        input logic [7:0] acc, input logic [3:0] eg,
                        input logic [7:0] ev);
        exp_t e;
        @(negedge Clk);
        chk("gen_idle", 32'(Gen), 32'd1);
        chk("busy_idle", 32'(Busy), 32'd0);
        Req    = req;
        Rnd_In = acc;
        @(posedge Clk);
        #1;
        e.g = eg;
        e.v = ev;
        e.c = cyc + 2 + nrej;
        sb.push_back(e);
        @(negedge Clk);
        if (!hold) Req = 4'b0000;
        chk("gen_seed", 32'(Gen), 32'd0);
        chk("busy_seed", 32'(Busy), 32'd1);
        @(posedge Clk);
        for (int i = 0; i <= nrej; i++) begin
            @(negedge Clk);
            Rnd_In = (i < nrej) ? rej : acc;
            chk("gen_sample", 32'(Gen), 32'd0);
            chk("busy_sample", 32'(Busy), 32'd1);
            @(posedge Clk);
        end
        @(negedge Clk);
        chk("gen_done", 32'(Gen), 32'd0);
        chk("busy_done", 32'(Busy), 32'd1);
        @(posedge Clk);
    endtask

    initial begin
        Rst        = 1'b0;
        Req        = 4'b0000;
        Range_Flat = 32'h0;
        Rnd_In     = 8'h00;
        #1;
        chk("rst_gen", 32'(Gen), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_rnd", 32'(Rnd_Out), 32'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);

        // Accept path: 0x3C&0xF=12 rejected, 0x25&0xF=5 accepted.
        Range_Flat = {8'd0, 8'd0, 8'd0, 8'd10};
        draw(4'b0001, 1'b0, 8'h3C, 1, 8'h25, 4'b0001, 8'd5);
        @(negedge Clk);
        chk("rnd_hold", 32'(Rnd_Out), 32'd5);
        chk("valid_idle", 32'(Valid), 32'd0);

        // Range edges.
        Range_Flat = {8'd0, 8'd0, 8'd0, 8'd0};
        draw(4'b0001, 1'b0, 8'h00, 0, 8'hA7, 4'b0001, 8'hA7);
        Range_Flat = {8'd0, 8'd0, 8'd0, 8'd1};
        draw(4'b0001, 1'b0, 8'h00, 0, 8'hFF, 4'b0001, 8'h00);
        Range_Flat = {8'd0, 8'd6, 8'd0, 8'd0};
        draw(4'b0100, 1'b0, 8'h0E, 1, 8'h0D, 4'b0100, 8'd5);

        // Fallback: eight samples of 12 -> 12-10 = 2.
        Range_Flat = {8'd0, 8'd0, 8'd0, 8'd10};
        draw(4'b0001, 1'b0, 8'h3C, 7, 8'h3C, 4'b0001, 8'd2);

        // Reset mid-SAMPLE aborts the draw.
        @(negedge Clk);
        Req    = 4'b0001;
        Rnd_In = 8'h3C;
        @(posedge Clk);
        @(negedge Clk);
        Req = 4'b0000;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("mid_rst_gen", 32'(Gen), 32'd1);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_valid", 32'(Valid), 32'd0);
        chk("mid_rst_grant", 32'(Grant), 32'd0);
        chk("mid_rst_rnd", 32'(Rnd_Out), 32'd0);
        Rnd_In = 8'h05;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        repeat (8) @(negedge Clk);
        chk("post_rst_busy", 32'(Busy), 32'd0);

        // Round-robin with all requests held.
        Range_Flat = 32'h0;
        draw(4'b1111, 1'b1, 8'h00, 0, 8'h11, 4'b0001, 8'h11);
        draw(4'b1111, 1'b1, 8'h00, 0, 8'h22, 4'b0010, 8'h22);
        draw(4'b1111, 1'b1, 8'h00, 0, 8'h33, 4'b0100, 8'h33);
        draw(4'b1111, 1'b1, 8'h00, 0, 8'h44, 4'b1000, 8'h44);
        draw(4'b1111, 1'b1, 8'h00, 0, 8'h55, 4'b0001, 8'h55);
        @(negedge Clk);
        Req = 4'b0000;
        repeat (6) @(negedge Clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
